// File: rtl/rf_dump_unit.sv
// rf_dump_unit
// -----------------------------------------------------------------------------
// End-of-run register-file dump engine for the pipelined CPU. It watches the
// fetch PC. When the PC reaches STOP_PC, or when the run-cycle budget
// CYCLE_LIMIT runs out, it freezes fetch. It then waits DRAIN_CYCLES cycles so
// in-flight instructions can write back. After that it streams the GPR file out
// over a valid/ready interface.
//
// Optional build macro:
//   RF_DUMP_HEADER_EN - prepend two header words (captured pc, captured inst)
//                       ahead of r0..r31; the dump then carries 34 words.
//
// Ports:
//   clock       in   system clock, rising edge
//   resetn      in   synchronous active-low reset
//   pc          in   CPU fetch PC
//   inst        in   instruction at pc
//   cpu_stall   out  fetch freeze (CPU holds PC, injects bubbles)
//   rf_raddr    out  register-file debug read address
//   rf_rdata    in   register-file debug read data (combinational from rf_raddr)
//   dump_valid  out  dump word valid
//   dump_ready  in   consumer accepts word when valid & ready
//   dump_data   out  dump word
//   dump_index  out  word number within the dump
//   dump_last   out  final word of the dump
//   done        out  dump complete, sticky until reset
//   timeout     out  run ended by CYCLE_LIMIT rather than STOP_PC
// -----------------------------------------------------------------------------
module rf_dump_unit #(
    parameter logic [31:0] STOP_PC      = 32'h00000048,
    parameter int unsigned CYCLE_LIMIT  = 1000,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned NREGS        = 32
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output logic        cpu_stall,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [31:0] dump_data,
    output logic [5:0]  dump_index,
    output logic        dump_last,
    output logic        done,
    output logic        timeout
);

`ifdef RF_DUMP_HEADER_EN
    localparam int unsigned HDR_WORDS = 2;
`else
    localparam int unsigned HDR_WORDS = 0;
`endif

    localparam logic [5:0]  FINAL_IDX  = 6'(NREGS + HDR_WORDS - 1);
    localparam bit          LIMIT_EN   = (CYCLE_LIMIT != 0);
    localparam logic [31:0] LIMIT_M1   = 32'(CYCLE_LIMIT - 1);
    // A zero drain setting still spends one cycle in DRAIN so the stall
    // reaches the CPU before the first register is read.
    localparam logic [15:0] DRAIN_LAST = (DRAIN_CYCLES == 0) ? 16'd0
                                                             : 16'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DUMP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] cycle_cnt;
    logic [15:0] drain_cnt;
    logic [5:0]  idx;
    logic [31:0] word_mux;
    logic        stop_hit;
    logic        limit_hit;
    logic        slot_free;
    logic        load_word;

    // The stall and done flags depend only on the state. State resets to RUN,
    // so both flags come out of reset low without separate registers.
    assign cpu_stall = (state != RUN);
    assign done      = (state == DONE);

    // Trigger detection, output-slot handshake and next-state selection.
    // The output slot can take a new word when it is empty or when its
    // current word is being accepted on this edge. That gives one word per
    // cycle while ready stays high.
    always_comb begin
        stop_hit   = (pc == STOP_PC);
        limit_hit  = LIMIT_EN && (cycle_cnt == LIMIT_M1);
        slot_free  = !dump_valid || dump_ready;
        load_word  = 1'b0;
        next_state = state;
        case (state)
            RUN: begin
                if (stop_hit || limit_hit) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    next_state = DUMP;
                end
            end
            DUMP: begin
                load_word = slot_free && (idx <= FINAL_IDX);
                if (dump_valid && dump_ready && dump_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = DONE;
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

`ifdef RF_DUMP_HEADER_EN
    logic [31:0] cap_pc;
    logic [31:0] cap_inst;

    // Capture the fetch pc/inst on the cycle the run ends.
    // They go out as the two header words.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cap_pc   <= '0;
            cap_inst <= '0;
        end else if ((state == RUN) && (stop_hit || limit_hit)) begin
            cap_pc   <= pc;
            cap_inst <= inst;
        end
    end

    // Word select with header: indices 0/1 are the captured pc/inst, and
    // index k >= 2 reads register k-2. The read address stays 0 for the
    // header words and outside the dump.
    always_comb begin
        rf_raddr = '0;
        word_mux = '0;
        if ((state == DUMP) && (idx >= 6'd2)) begin
            rf_raddr = 5'(idx - 6'd2);
        end
        if (idx == 6'd0) begin
            word_mux = cap_pc;
        end else if (idx == 6'd1) begin
            word_mux = cap_inst;
        end else if (rf_raddr != 5'd0) begin
            word_mux = rf_rdata;
        end
    end
`else
    // The instruction word only feeds the header build.
    logic unused_inst;
    assign unused_inst = ^inst;

    // Word select without header: the dump index is the register number.
    // r0 is forced to zero whatever the register file returns.
    always_comb begin
        rf_raddr = '0;
        word_mux = '0;
        if (state == DUMP) begin
            rf_raddr = idx[4:0];
        end
        if (rf_raddr != 5'd0) begin
            word_mux = rf_rdata;
        end
    end
`endif

    // Datapath registers: run-cycle counter, drain counter, dump index, and
    // the registered output slot.
    // In RUN the cycle counter saturates so a long run cannot wrap back onto
    // the limit. timeout is set only when the budget ends the run and the stop
    // address does not match on the same cycle.
    // In DUMP the slot keeps its contents while valid is high and ready is low.
    // Once the last word is accepted the slot empties.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cycle_cnt  <= '0;
            drain_cnt  <= '0;
            idx        <= '0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_index <= '0;
            dump_last  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (cycle_cnt != '1) begin
                        cycle_cnt <= cycle_cnt + 32'd1;
                    end
                    if (!stop_hit && limit_hit) begin
                        timeout <= 1'b1;
                    end
                    drain_cnt <= '0;
                    idx       <= '0;
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 16'd1;
                end
                DUMP: begin
                    if (load_word) begin
                        dump_data  <= word_mux;
                        dump_index <= idx;
                        dump_last  <= (idx == FINAL_IDX);
                        dump_valid <= 1'b1;
                        idx        <= idx + 6'd1;
                    end else if (dump_valid && dump_ready) begin
                        dump_valid <= 1'b0;
                        dump_last  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_dump_unit.sv
`timescale 1ns/1ps
module tb_rf_dump_unit;

    localparam logic [31:0] STOP_PC     = 32'h00000048;
    localparam int          CYCLE_LIMIT = 1000;
`ifdef RF_DUMP_HEADER_EN
    localparam int          NWORDS      = 34;
`else
    localparam int          NWORDS      = 32;
`endif
    localparam int          HDR         = NWORDS - 32;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        cpu_stall;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic [5:0]  dump_index;
    logic        dump_last;
    logic        done;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  index;
        logic        last;
    } word_t;

    // One row per run scenario. The inputs are the cycle where pc is forced to
    // STOP_PC (-1 means never), the pc base, and the ready pattern. The
    // expected outputs are the trigger cycle and the timeout flag.
    typedef struct {
        int          stop_cycle;
        logic [31:0] pc_base;
        int          ready_mode;
        int          exp_trig;
        logic        exp_timeout;
    } vec_t;

    vec_t  vecs[5];
    word_t sbq[$];

    rf_dump_unit dut (
        .clock      (clock),
        .resetn     (resetn),
        .pc         (pc),
        .inst       (inst),
        .cpu_stall  (cpu_stall),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_index (dump_index),
        .dump_last  (dump_last),
        .done       (done),
        .timeout    (timeout)
    );

    always #5 clock = ~clock;

    // Register-file model: rf[k] = k*0x11111111. r0 deliberately reads as
    // garbage so the DUT must force it to zero itself.
    assign rf_rdata = (rf_raddr == 5'd0) ? 32'hDEADBEEF
                                         : (32'(rf_raddr) * 32'h11111111);

    function automatic logic [31:0] regValue(input int r);
        return (r == 0) ? 32'h0 : (32'(r) * 32'h11111111);
    endfunction

    function automatic logic [31:0] instFor(input logic [31:0] p);
        return (p == STOP_PC) ? 32'h08000012 : (p ^ 32'h13572468);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] p, input logic r);
        pc         = p;
        inst       = instFor(p);
        dump_ready = r;
    endtask

    task automatic pushExpected(input logic [31:0] cpc, input logic [31:0] cinst);
        for (int k = 0; k < NWORDS; k++) begin
            word_t w;
            w.index = 6'(k);
            w.last  = (k == NWORDS - 1);
            if (k < HDR) begin
                w.data = (k == 0) ? cpc : cinst;
            end else begin
                w.data = regValue(k - HDR);
            end
            sbq.push_back(w);
        end
    endtask

    task automatic doReset();
        @(negedge clock);
        resetn = 1'b0;
        applyStimulus(32'h0, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic checkResetState(input string tag);
        checkBit({tag, "_stall"}, cpu_stall, 1'b0);
        checkBit({tag, "_valid"}, dump_valid, 1'b0);
        checkBit({tag, "_done"}, done, 1'b0);
        checkBit({tag, "_timeout"}, timeout, 1'b0);
        checkBit({tag, "_last"}, dump_last, 1'b0);
        checkOutput({tag, "_data"}, dump_data, 32'h0);
        checkOutput({tag, "_index"}, 32'(dump_index), 32'h0);
        checkOutput({tag, "_raddr"}, 32'(rf_raddr), 32'h0);
    endtask

    // Runs one scenario from a fresh reset, starting at the negedge just
    // before the first active edge. If abort_idx >= 0, the scenario applies a
    // one-edge reset right after that word index is accepted and returns.
    task automatic runScenario(input vec_t v, input bit do_reset, input int abort_idx);
        int          sent;
        bit          seen_done;
        bit          holding;
        bit          aborting;
        word_t       held;
        word_t       exp_w;
        logic [31:0] cur_pc;
        logic        r;

        if (do_reset) doReset();
        checkResetState("reset");
        sbq.delete();
        sent      = 0;
        seen_done = 0;
        holding   = 0;
        aborting  = 0;
        cur_pc    = 32'h0;
        held      = '{32'h0, 6'h0, 1'b0};

        for (int n = 0; (n < v.exp_trig + 400) && !seen_done && !aborting; n++) begin
            if (holding) begin
                checkBit("hold_valid", dump_valid, 1'b1);
                checkOutput("hold_data", dump_data, held.data);
                checkOutput("hold_index", 32'(dump_index), 32'(held.index));
                checkBit("hold_last", dump_last, held.last);
            end
            if (!cpu_stall) begin
                cur_pc = (n == v.stop_cycle) ? STOP_PC : (v.pc_base + 32'(4 * n));
            end
            case (v.ready_mode)
                0:       r = 1'b1;
                1:       r = ((n % 3) == 0);
                default: r = 1'($urandom_range(1, 0));
            endcase
            applyStimulus(cur_pc, r);

            if (n == v.exp_trig) begin
                checkBit("pre_stall", cpu_stall, 1'b0);
                pushExpected(cur_pc, inst);
            end
            if (n == v.exp_trig + 1) begin
                checkBit("stall_rise", cpu_stall, 1'b1);
                checkBit("timeout_flag", timeout, v.exp_timeout);
            end
            if (n == v.exp_trig + 5) checkBit("valid_early", dump_valid, 1'b0);
            if (n == v.exp_trig + 6) checkBit("first_valid", dump_valid, 1'b1);

            holding = dump_valid && !dump_ready;
            if (holding) begin
                held.data  = dump_data;
                held.index = dump_index;
                held.last  = dump_last;
            end
            if (dump_valid && dump_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL extra_word actual index=%0d required none", dump_index);
                end else begin
                    exp_w = sbq.pop_front();
                    checkOutput("word_data", dump_data, exp_w.data);
                    checkOutput("word_index", 32'(dump_index), 32'(exp_w.index));
                    checkBit("word_last", dump_last, exp_w.last);
                end
                sent++;
                if ((abort_idx >= 0) && (dump_index == 6'(abort_idx))) aborting = 1;
            end
            if (done) seen_done = 1;
            @(negedge clock);
        end

        if (aborting) begin
            resetn = 1'b0;
            @(negedge clock);
            resetn = 1'b1;
            checkResetState("midreset");
            sbq.delete();
        end else if (!seen_done) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_wait actual done=0 required done=1 within budget");
        end else begin
            checkOutput("word_count", 32'(sent), 32'(NWORDS));
            checkOutput("sb_left", 32'(sbq.size()), 32'h0);
            checkBit("end_done", done, 1'b1);
            checkBit("end_timeout", timeout, v.exp_timeout);
            checkBit("end_stall", cpu_stall, 1'b1);
            checkBit("end_valid", dump_valid, 1'b0);
            repeat (5) begin
                applyStimulus(STOP_PC, 1'b1);
                @(negedge clock);
            end
            checkBit("done_sticky", done, 1'b1);
            checkBit("no_redump", dump_valid, 1'b0);
            checkBit("stall_sticky", cpu_stall, 1'b1);
        end
    endtask

    initial begin
        resetn     = 1'b0;
        pc         = 32'h0;
        inst       = 32'h0;
        dump_ready = 1'b0;

        // stop dump at cycle 18, full-rate ready
        vecs[0] = '{18, 32'h0000_0000, 0, 18, 1'b0};
        // stop dump with ready pattern 1,0,0
        vecs[1] = '{18, 32'h0000_0000, 1, 18, 1'b0};
        // timeout: pc never hits STOP_PC
        vecs[2] = '{-1, 32'h0000_1000, 0, CYCLE_LIMIT - 1, 1'b1};
        // stop and budget expire on the same cycle
        vecs[3] = '{CYCLE_LIMIT - 1, 32'h0000_1000, 1, CYCLE_LIMIT - 1, 1'b0};
        // early stop with random ready
        vecs[4] = '{5, 32'h0000_1000, 2, 5, 1'b0};

        for (int i = 0; i < 5; i++) begin
            $display("[TB] scenario %0d", i);
            runScenario(vecs[i], 1'b1, -1);
        end

        $display("[TB] reset mid-dump after word 10, then retrigger");
        runScenario(vecs[0], 1'b1, 10);
        runScenario(vecs[1], 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
